// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to its consumer.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized row sampling,
// per-round hit classification and a press/release debounce FSM.
module keypad_scanner #(
  parameter int unsigned T1ms      = 100000,
  parameter int unsigned DB_ROUNDS = 2
) (
  input  logic               clk,
  input  logic               rst_n,   // active-high synchronous reset
  input  logic [3:0]         row,
  output logic [3:0]         col,
  keypad_scanner_if.master   key
);

  localparam int unsigned CW = (T1ms > 1) ? $clog2(T1ms) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(T1ms - 1);
  localparam logic [3:0]    DB = 4'(DB_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic [CW-1:0] dwell_q, dwell_d;
  logic [3:0]    row_meta_q, row_sync_q;
  logic [3:0]    col_q, col_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  logic          tick, round_end;
  logic [1:0]    cur_cnt, tot_cnt;
  logic [3:0]    cur_code, tot_code;
  logic          res_none, res_single;
  logic [3:0]    new_cnt, new_cand;

  assign tick      = (dwell_q == DWELL_LAST);
  assign round_end = tick && (col_idx_q == 2'd3);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  // Dwell counter and column rotation.
  always_comb begin
    dwell_d   = tick ? '0 : dwell_q + CW'(1);
    col_d     = tick ? {col_q[2:0], col_q[3]} : col_q;
    col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
  end

  // Hits in the currently driven column (count saturates at 2 = MULTI).
  always_comb begin
    cur_cnt  = 2'd0;
    cur_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        cur_cnt  = (cur_cnt == 2'd0) ? 2'd1 : 2'd2;
        cur_code = {2'(r), col_idx_q};
      end
    end
  end

  // Merge this column's hits with the ones accumulated earlier in the round;
  // the col-3 result is used directly so the round closes on that tick.
  always_comb begin
    tot_cnt    = (acc_cnt_q + cur_cnt > 2'd2) ? 2'd2 : acc_cnt_q + cur_cnt;
    if ((acc_cnt_q == 2'd2) || (cur_cnt == 2'd2)) tot_cnt = 2'd2;
    tot_code   = (acc_cnt_q != 2'd0) ? acc_code_q : cur_code;
    res_none   = (tot_cnt == 2'd0);
    res_single = (tot_cnt == 2'd1);
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      acc_cnt_d  = round_end ? 2'd0 : tot_cnt;
      acc_code_d = round_end ? '0 : tot_code;
    end
  end

  // Scan datapath registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dwell_q    <= '0;
      col_q      <= 4'b1110;
      col_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Debounce FSM next state; everything advances only at round end.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    rnd_d       = rnd_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    new_cnt     = 4'd1;
    new_cand    = tot_code;
    if (round_end) begin
      unique case (state_q)
        IDLE, PRESS_CHK: begin
          if (res_single) begin
            if ((state_q == PRESS_CHK) && (tot_code == cand_q)) begin
              new_cnt = rnd_q + 4'd1;
            end
            if (new_cnt == DB) begin
              state_d     = HELD;
              cand_d      = new_cand;
              rnd_d       = '0;
              key_code_d  = new_cand;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              state_d = PRESS_CHK;
              cand_d  = new_cand;
              rnd_d   = new_cnt;
            end
          end else begin
            state_d = IDLE;
            rnd_d   = '0;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DB == 4'd1) begin
              state_d    = IDLE;
              rnd_d      = '0;
              key_down_d = 1'b0;
            end else begin
              state_d = RELEASE_CHK;
              rnd_d   = 4'd1;
            end
          end
        end
        RELEASE_CHK: begin
          if (res_none) begin
            if (rnd_q + 4'd1 == DB) begin
              state_d    = IDLE;
              rnd_d      = '0;
              key_down_d = 1'b0;
            end else begin
              rnd_d = rnd_q + 4'd1;
            end
          end else begin
            state_d = HELD;
            rnd_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Debounce FSM state and key output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      rnd_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      rnd_q       <= rnd_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col           = col_q;
  assign key.key_code  = key_code_q;
  assign key.key_valid = key_valid_q;
  assign key.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
`timescale 1ns/1ps
module tb_keypad_scanner;
  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed;
  int          checks;
  int          errors;
  int          pulses;
  int          n;

  keypad_scanner_if kif ();

  keypad_scanner #(.T1ms(4), .DB_ROUNDS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .key   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key (r,c) shorts row r to column c.
  always_comb begin
    row = '1;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && !col[k[1:0]]) row[k[3:2]] = 1'b0;
    end
  end

  // key_valid read before the edge's updates land: previous cycle's value.
  always @(posedge clk) begin
    if (kif.key_valid === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_up(input int maxc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (kif.key_down === 1'b0) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] ec [4];
    int i;
    ec = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    checks = 0; errors = 0; pulses = 0;
    pressed = '0;
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_code", kif.key_code, 4'h0);
    check("rst_valid", kif.key_valid, 1'b0);
    check("rst_down", kif.key_down, 1'b0);
    rst_n = 1'b0;

    // Column rotation every 4 clocks after release.
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check($sformatf("col_step%0d", k), col, ec[k]);
    end
    repeat (32) @(negedge clk);
    check("idle_pulses", pulses, 0);
    check("idle_down", kif.key_down, 1'b0);

    // Hold F, expect one pulse.
    pressed[15] = 1'b1;
    wait_valid(60, n);
    check("press_F_in_time", (n >= 1 && n <= 51), 1'b1);
    check("press_F_code", kif.key_code, 4'hF);
    check("press_F_down", kif.key_down, 1'b1);
    @(negedge clk);
    check("press_F_one_cycle", kif.key_valid, 1'b0);
    repeat (40) @(negedge clk);
    check("held_F_pulses", pulses, 1);
    check("held_F_down", kif.key_down, 1'b1);

    // Release F.
    pressed = '0;
    wait_up(60, n);
    check("release_F_in_time", (n >= 1 && n <= 51), 1'b1);
    check("release_F_code_kept", kif.key_code, 4'hF);
    check("release_F_pulses", pulses, 1);

    // Short 10-clock press of C.
    repeat (8) @(negedge clk);
    pressed[12] = 1'b1;
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (60) @(negedge clk);
    check("short_C_pulses", pulses, 1);
    check("short_C_down", kif.key_down, 1'b0);

    // 5 and 6 together: MULTI, then 5 alone qualifies.
    pressed[5] = 1'b1;
    pressed[6] = 1'b1;
    repeat (80) @(negedge clk);
    check("multi_pulses", pulses, 1);
    check("multi_down", kif.key_down, 1'b0);
    pressed[6] = 1'b0;
    wait_valid(60, n);
    check("press_5_in_time", (n >= 1 && n <= 51), 1'b1);
    check("press_5_code", kif.key_code, 4'h5);
    repeat (5) @(negedge clk);
    check("press_5_pulses", pulses, 2);
    pressed = '0;
    wait_up(60, n);
    check("release_5_in_time", (n >= 1 && n <= 51), 1'b1);

    // Align to a round start, press 9, reset while in PRESS_CHK.
    i = 0;
    do begin @(negedge clk); i++; end while (col !== 4'b0111 && i < 20);
    i = 0;
    do begin @(negedge clk); i++; end while (col !== 4'b1110 && i < 8);
    check("align_col", col, 4'b1110);
    pressed[9] = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_col", col, 4'b1110);
    check("midrst_code", kif.key_code, 4'h0);
    check("midrst_valid", kif.key_valid, 1'b0);
    check("midrst_down", kif.key_down, 1'b0);
    rst_n = 1'b0;
    wait_valid(60, n);
    check("rereport_latency", n, 32);
    check("rereport_code", kif.key_code, 4'h9);
    check("rereport_down", kif.key_down, 1'b1);
    repeat (40) @(negedge clk);
    check("rereport_pulses", pulses, 3);
    pressed = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter T1ms, default 100000: clk cycles per column dwell; legal range 4..2^20.
REQ-002 Parameter DB_ROUNDS, default 2: consecutive identical full scan rounds required to confirm a press or a release; legal range 1..15.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-high reset (1 = reset, 0 = run), sampled on rising clk.
REQ-005 row  in  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 col  out  4  keypad column drive, one-cold.
REQ-007 key_code  out  4  last confirmed key, {row_index[1:0], col_index[1:0]}.
REQ-008 key_valid  out  1  single-cycle pulse on press confirmation.
REQ-009 key_down  out  1  level; high from press confirmation until release confirmation.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Dwell counter SHALL count 0..T1ms-1 and wrap; the cycle where it equals T1ms-1 is the "tick".
REQ-012 On each tick the block SHALL sample synchronized row for the current column, then rotate col: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-013 Column c driven low and row bit r sampled low SHALL record a hit with code {r, c}.
REQ-014 A round SHALL be the four ticks for col index 0..3; it ends on the col-3 tick.
REQ-015 Round result: zero hits = NONE; exactly one hit = that code; two or more hits = MULTI.
REQ-016 FSM states: IDLE, PRESS_CHK, HELD, RELEASE_CHK; state and round counter update only at round end.
REQ-017 IDLE: a single-code result -> PRESS_CHK, candidate = code, count = 1; NONE or MULTI -> stay in IDLE.
REQ-018 PRESS_CHK: same code -> count+1; different single code -> restart with the new candidate, count = 1; NONE or MULTI -> IDLE.
REQ-019 When count reaches DB_ROUNDS (including DB_ROUNDS = 1, on the first round), the FSM SHALL enter HELD, load key_code = candidate, pulse key_valid for exactly the following clk cycle, and set key_down = 1.
REQ-020 HELD: NONE -> RELEASE_CHK, count = 1; any other result -> stay; key_valid SHALL NOT repeat while held.
REQ-021 RELEASE_CHK: NONE -> count+1; count reaching DB_ROUNDS -> IDLE, key_down = 0; any non-NONE result -> HELD.
REQ-022 key_code SHALL hold its value until the next press confirmation; release does not clear it.
REQ-023 Worst-case press latency SHALL be (DB_ROUNDS+1)*4*T1ms + 3 clk cycles from a stable row change.
REQ-024 A key pressed or released mid-round SHALL affect only the rounds that actually sample it; no other special handling.
REQ-025 A new key pressed while HELD SHALL NOT be reported until release is confirmed and the new press re-qualifies.

Reset
REQ-026 During reset: col = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, state = IDLE, dwell counter, round counter and synchronizer = 0 / idle.
REQ-027 Reset asserted mid-operation SHALL discard any pending candidate and emit no key_valid; a key still held after reset SHALL be re-reported after DB_ROUNDS rounds.
REQ-028 The first tick after reset release SHALL occur T1ms cycles after rst_n falls.

Verification (T1ms=4, DB_ROUNDS=2, keypad model row[r] = col[c] for the pressed key)
REQ-029 Reset then idle, no key -> col cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts; key_down = 0.
REQ-030 Hold key r=3,c=3 -> exactly one key_valid pulse with key_code = 4'hF within 51 clk; key_down = 1 while held.
REQ-031 Release after REQ-030 -> key_down falls within 51 clk; key_code stays 4'hF; no key_valid pulse.
REQ-032 Press r=3,c=0 (code 4'hC) for 10 clk only -> no key_valid.
REQ-033 Press codes 4'h5 and 4'h6 simultaneously -> no key_valid; after releasing 4'h6, one pulse with key_code = 4'h5.
REQ-034 Assert rst_n for 1 cycle while a key is in PRESS_CHK -> outputs return to their reset values; the held key is reported once after 2 further rounds.
